// File: rtl/skew_delay_pkg.sv
// Shared types and delay-profile helpers for the operand skew/deskew delay array.
// Channel delays form a triangular profile: rising for SKEW, falling for DESKEW.
package skew_delay_pkg;

    typedef enum logic {
        SKEW   = 1'b0,
        DESKEW = 1'b1
    } skew_mode_e;

    function automatic int chan_delay(input int c, input int ch, input int base, input int mode);
        if (mode == int'(DESKEW)) begin
            return base + (ch - 1 - c);
        end
        return base + c;
    endfunction

    function automatic int total_stages(input int ch, input int base);
        return ch * base + (ch * (ch - 1)) / 2;
    endfunction

    function automatic int sum_delays(input int ch, input int base, input int mode);
        int acc;
        acc = 0;
        for (int c = 0; c < ch; c++) begin
            acc += chan_delay(c, ch, base, mode);
        end
        return acc;
    endfunction

endpackage

// File: rtl/skew_delay_array_if.sv
// Operand-edge bus of the delay array: per-channel valid bits plus packed channel data.
interface skew_delay_array_if #(
    parameter int CH  = 4,
    parameter int D_W = 8
);
    logic [CH-1:0]     in_valid;
    logic [CH*D_W-1:0] in_data;
    logic [CH-1:0]     out_valid;
    logic [CH*D_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/skew_delay_array_delay_chain.sv
// Single-channel shift chain of DEPTH {valid, data} registers; valid is the MSB of each word.
// busy reports whether any stage currently holds a valid beat.
module delay_chain #(
    parameter int W     = 9,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         busy
);

    logic [DEPTH-1:0] vld;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] stage_reg;
            logic [W-1:0] stage_next;

            if (gi == 0) begin : g_head
                assign stage_next = d;
            end else begin : g_link
                assign stage_next = g_stage[gi-1].stage_reg;
            end

            // Flush wins over a stalled enable so in-flight beats can always be dropped.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_reg <= '0;
                end else if (flush) begin
                    stage_reg <= '0;
                end else if (en) begin
                    stage_reg <= stage_next;
                end
            end

            assign vld[gi] = stage_reg[W-1];
        end
    endgenerate

    assign q    = g_stage[DEPTH-1].stage_reg;
    assign busy = |vld;

endmodule

// File: rtl/skew_delay_array.sv
// Multi-channel triangular delay line placed at the systolic-array edges.
// Each channel is an independent delay_chain; only en and flush are shared.
module skew_delay_array
    import skew_delay_pkg::*;
#(
    parameter int D_W  = 8,
    parameter int CH   = 4,
    parameter int BASE = 1,
    parameter int MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    skew_delay_array_if.slave    bus,
    output logic                 idle
);

    localparam int TOTAL_STAGES = total_stages(CH, BASE);

    generate
        if (BASE < 1) begin : g_bad_base
            $error("skew_delay_array: BASE must be at least 1");
        end
        if (sum_delays(CH, BASE, MODE) != TOTAL_STAGES) begin : g_bad_profile
            $error("skew_delay_array: channel delays do not sum to the stage count");
        end
    endgenerate

    logic [CH-1:0] busy_w;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            logic [D_W:0] d_w;
            logic [D_W:0] q_w;

            assign d_w = {bus.in_valid[gi], bus.in_data[gi*D_W +: D_W]};

            delay_chain #(
                .W     (D_W + 1),
                .DEPTH (chan_delay(gi, CH, BASE, MODE))
            ) u_chain (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .flush (flush),
                .d     (d_w),
                .q     (q_w),
                .busy  (busy_w[gi])
            );

            assign bus.out_valid[gi]            = q_w[D_W];
            assign bus.out_data[gi*D_W +: D_W]  = q_w[D_W-1:0];
        end
    endgenerate

    assign idle = ~|busy_w;

endmodule
